tick_req_scheduler: RTL
=======================

TICK_REQ_SCHEDULER -- requirements
Module: tick_req_scheduler

Interface
REQ-001 Parameter PERIOD, default 400001, SHALL be the expected spacing of tick pulses in clk cycles.
REQ-002 Parameter TICKS_PER_REQ, default 16, SHALL be the number of ticks per request (>=2).
REQ-003 Parameter ACK_TIMEOUT, default 4, SHALL be the number of ticks allowed for ack while req is high (>=1).
REQ-004 clk  in  1  clock; all logic SHALL be rising-edge clk only.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 tick  in  1  single-cycle periodic pulse from the upstream delay/tick generator.
REQ-007 ack  in  1  downstream acknowledge of req.
REQ-008 req  out  1  request to the downstream agent, level, held until ack or timeout.
REQ-009 done  out  1  one-cycle pulse on each acknowledged request.
REQ-010 timeout_err  out  1  one-cycle pulse on each request abandoned by timeout.
REQ-011 tick_lost  out  1  sticky flag: a tick failed to arrive within PERIOD cycles.
REQ-012 req_count  out  16  number of acknowledged requests since reset.

Function
REQ-013 FSM SHALL have exactly two states, IDLE and WAIT_ACK; reset state IDLE.
REQ-014 In IDLE, each tick SHALL increment tick_cnt (width clog2(TICKS_PER_REQ)); a tick arriving with tick_cnt == TICKS_PER_REQ-1 SHALL clear tick_cnt and enter WAIT_ACK, with req = 1 from the following cycle.
REQ-015 req SHALL equal 1 exactly when state is WAIT_ACK (registered, no combinational path from any input).
REQ-016 On entry to WAIT_ACK, wait_cnt SHALL be 0; each tick in WAIT_ACK SHALL increment wait_cnt.
REQ-017 ack sampled high in WAIT_ACK SHALL: return to IDLE, pulse done next cycle, increment req_count (wrap 0xFFFF -> 0).
REQ-018 A tick in WAIT_ACK with wait_cnt == ACK_TIMEOUT-1 and ack low SHALL: return to IDLE, pulse timeout_err next cycle, leave req_count unchanged.
REQ-019 Simultaneous ack and timeout tick: ack SHALL win (done, no timeout_err).
REQ-020 ack in IDLE SHALL be ignored.
REQ-021 Ticks in WAIT_ACK SHALL NOT advance tick_cnt; counting toward the next request SHALL restart from 0 on return to IDLE.
REQ-022 done and timeout_err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per event.
REQ-023 Watchdog: gap_cnt SHALL clear on tick and otherwise increment, saturating at PERIOD+1; tick_lost SHALL set when gap_cnt reaches PERIOD+1 without a tick and hold until rst.
REQ-024 A tick exactly PERIOD cycles after the previous tick (or after rst release) SHALL NOT set tick_lost.

Reset
REQ-025 rst SHALL force state IDLE, tick_cnt = 0, wait_cnt = 0, gap_cnt = 0, and all outputs to 0 (req, done, timeout_err, tick_lost, req_count).
REQ-026 rst asserted mid-request SHALL drop req the next cycle with no done or timeout_err pulse; rst SHALL take priority over tick and ack in the same cycle.

Configuration
REQ-027 Macro TICK_SCHED_WATCHDOG_EN defined: watchdog per REQ-023/024 SHALL be present.
REQ-028 Macro undefined: gap_cnt SHALL be absent and tick_lost SHALL be tied 0; all other behaviour unchanged.

Structure
REQ-029 Package tick_sched_pkg SHALL hold the state enum (IDLE, WAIT_ACK) and the default values of PERIOD, TICKS_PER_REQ, ACK_TIMEOUT.
REQ-030 Watchdog SHALL be a sub-module tick_watchdog (clk, rst, tick, tick_lost, parameter PERIOD), instantiated only under TICK_SCHED_WATCHDOG_EN.

Verification (PERIOD=5, TICKS_PER_REQ=4, ACK_TIMEOUT=2, watchdog enabled)
REQ-031 Ticks every 5 cycles, ack 3 cycles after req rises -> req high after 4th tick, done one pulse, req_count = 1, tick_lost = 0.
REQ-032 ack never asserted -> req high for exactly 2 ticks, then timeout_err one pulse, req_count = 0, next req after 4 further ticks.
REQ-033 ack asserted in the same cycle as the 2nd tick in WAIT_ACK -> done pulses, timeout_err stays 0, req_count = 1.
REQ-034 Tick stream stops -> tick_lost = 1 exactly 6 cycles after last tick, stays 1 after ticks resume, clears only on rst.
REQ-035 rst pulsed while req = 1 -> req = 0 next cycle, no done or timeout_err, req_count = 0, first req after 4 ticks.
REQ-036 ack pulses while in IDLE -> no effect on req, done or req_count.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared types and parameter defaults for the tick-driven request scheduler.
// Imported by the interface, the scheduler top and the watchdog.
package tick_sched_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } sched_state_t;

  localparam int DEFAULT_PERIOD        = 400001;
  localparam int DEFAULT_TICKS_PER_REQ = 16;
  localparam int DEFAULT_ACK_TIMEOUT   = 4;
  localparam int REQ_COUNT_W           = 16;

  // Bits needed to hold 0..maxVal, never less than one.
  function automatic int cntWidth(input int maxVal);
    int w;
    w = $clog2(maxVal + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tick_req_scheduler_if.sv
// Handshake bundle between the tick source / downstream agent and the scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface tick_req_scheduler_if;
  import tick_sched_pkg::*;

  logic                   tick;
  logic                   ack;
  logic                   req;
  logic                   done;
  logic                   timeout_err;
  logic                   tick_lost;
  logic [REQ_COUNT_W-1:0] req_count;

  modport slave (
    input  tick,
    input  ack,
    output req,
    output done,
    output timeout_err,
    output tick_lost,
    output req_count
  );

  modport master (
    output tick,
    output ack,
    input  req,
    input  done,
    input  timeout_err,
    input  tick_lost,
    input  req_count
  );

endinterface

// File: rtl/tick_watchdog.sv
// Sticky detector for a missing tick: flags once PERIOD+1 cycles pass without one.
// A tick arriving exactly PERIOD cycles after the previous one is on time.
module tick_watchdog
  import tick_sched_pkg::*;
#(
  parameter int PERIOD = DEFAULT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic tick_lost
);

  localparam int GW = cntWidth(PERIOD + 1);
  localparam logic [GW-1:0] GAP_SAT   = GW'(PERIOD + 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(PERIOD);

  logic [GW-1:0] r_gapCnt;
  logic          r_tickLost;

  // The flag rises on the same edge that the gap counter reaches PERIOD+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gapCnt   <= '0;
      r_tickLost <= 1'b0;
    end else begin
      if (tick) begin
        r_gapCnt <= '0;
      end else if (r_gapCnt != GAP_SAT) begin
        r_gapCnt <= r_gapCnt + 1'b1;
      end
      if (!tick && (r_gapCnt >= GAP_LIMIT)) begin
        r_tickLost <= 1'b1;
      end
    end
  end

  assign tick_lost = r_tickLost;

endmodule

// File: rtl/tick_req_scheduler.sv
// Raises req every TICKS_PER_REQ ticks and waits up to ACK_TIMEOUT ticks for ack.
// Define TICK_SCHED_WATCHDOG_EN to include the missing-tick watchdog.
module tick_req_scheduler
  import tick_sched_pkg::*;
#(
  parameter int PERIOD        = DEFAULT_PERIOD,
  parameter int TICKS_PER_REQ = DEFAULT_TICKS_PER_REQ,
  parameter int ACK_TIMEOUT   = DEFAULT_ACK_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst,
  tick_req_scheduler_if.slave bus
);

  localparam int TW = cntWidth(TICKS_PER_REQ - 1);
  localparam int WW = cntWidth(ACK_TIMEOUT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_REQ - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);

  if ((PERIOD < 1) || (TICKS_PER_REQ < 2) || (ACK_TIMEOUT < 1)) begin : g_badParams
    $error("tick_req_scheduler: PERIOD>=1, TICKS_PER_REQ>=2, ACK_TIMEOUT>=1 required");
  end

  sched_state_t           r_state;
  logic [TW-1:0]          r_tickCnt;
  logic [WW-1:0]          r_waitCnt;
  logic                   r_done;
  logic                   r_timeoutErr;
  logic [REQ_COUNT_W-1:0] r_reqCount;

  sched_state_t           w_nextState;
  logic [TW-1:0]          w_nextTickCnt;
  logic [WW-1:0]          w_nextWaitCnt;
  logic                   w_nextDone;
  logic                   w_nextTimeoutErr;
  logic [REQ_COUNT_W-1:0] w_nextReqCount;
  logic                   w_tickLost;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_tickCnt    <= '0;
      r_waitCnt    <= '0;
      r_done       <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_reqCount   <= '0;
    end else begin
      r_state      <= w_nextState;
      r_tickCnt    <= w_nextTickCnt;
      r_waitCnt    <= w_nextWaitCnt;
      r_done       <= w_nextDone;
      r_timeoutErr <= w_nextTimeoutErr;
      r_reqCount   <= w_nextReqCount;
    end
  end

  // Ack is checked before the timeout tick so a simultaneous ack still counts.
  always_comb begin
    w_nextState      = r_state;
    w_nextTickCnt    = r_tickCnt;
    w_nextWaitCnt    = r_waitCnt;
    w_nextDone       = 1'b0;
    w_nextTimeoutErr = 1'b0;
    w_nextReqCount   = r_reqCount;

    unique case (r_state)
      IDLE: begin
        if (bus.tick) begin
          if (r_tickCnt == TICK_LAST) begin
            w_nextTickCnt = '0;
            w_nextWaitCnt = '0;
            w_nextState   = WAIT_ACK;
          end else begin
            w_nextTickCnt = r_tickCnt + 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (bus.ack) begin
          w_nextState    = IDLE;
          w_nextDone     = 1'b1;
          w_nextReqCount = r_reqCount + 1'b1;
          w_nextTickCnt  = '0;
          w_nextWaitCnt  = '0;
        end else if (bus.tick) begin
          if (r_waitCnt == WAIT_LAST) begin
            w_nextState      = IDLE;
            w_nextTimeoutErr = 1'b1;
            w_nextTickCnt    = '0;
            w_nextWaitCnt    = '0;
          end else begin
            w_nextWaitCnt = r_waitCnt + 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

`ifdef TICK_SCHED_WATCHDOG_EN
  tick_watchdog #(
    .PERIOD(PERIOD)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .tick     (bus.tick),
    .tick_lost(w_tickLost)
  );
`else
  assign w_tickLost = 1'b0;
`endif

  assign bus.req         = (r_state == WAIT_ACK);
  assign bus.done        = r_done;
  assign bus.timeout_err = r_timeoutErr;
  assign bus.tick_lost   = w_tickLost;
  assign bus.req_count   = r_reqCount;

endmodule
